// File: rtl/l2mp_trace_replayer_if.sv
// Loader-side record stream into the replayer and the emit-side strobe bus out of it.
// The master drives records and watches emits; the replayer sits on the slave modport.
interface l2mp_trace_replayer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_metaWway;
  logic        in_metaWvalid;
  logic [7:0]  in_mshrId;
  logic [7:0]  in_allocPtr;
  logic        in_allocValid;
  logic [2:0]  in_dirWay;
  logic        in_dirHit;
  logic [8:0]  in_sset;
  logic [18:0] in_tag;
  logic [2:0]  in_opcode;
  logic [2:0]  in_channel;
  logic        in_mshrTask;
  logic [63:0] in_stamp;

  logic        out_valid;
  logic [2:0]  out_metaWway;
  logic        out_metaWvalid;
  logic [7:0]  out_mshrId;
  logic [7:0]  out_allocPtr;
  logic        out_allocValid;
  logic [2:0]  out_dirWay;
  logic        out_dirHit;
  logic [8:0]  out_sset;
  logic [18:0] out_tag;
  logic [2:0]  out_opcode;
  logic [2:0]  out_channel;
  logic        out_mshrTask;
  logic [63:0] out_stamp;

  modport master (
    output in_valid, in_metaWway, in_metaWvalid, in_mshrId, in_allocPtr, in_allocValid,
           in_dirWay, in_dirHit, in_sset, in_tag, in_opcode, in_channel, in_mshrTask, in_stamp,
    input  in_ready,
    input  out_valid, out_metaWway, out_metaWvalid, out_mshrId, out_allocPtr, out_allocValid,
           out_dirWay, out_dirHit, out_sset, out_tag, out_opcode, out_channel, out_mshrTask,
           out_stamp
  );

  modport slave (
    input  in_valid, in_metaWway, in_metaWvalid, in_mshrId, in_allocPtr, in_allocValid,
           in_dirWay, in_dirHit, in_sset, in_tag, in_opcode, in_channel, in_mshrTask, in_stamp,
    output in_ready,
    output out_valid, out_metaWway, out_metaWvalid, out_mshrId, out_allocPtr, out_allocValid,
           out_dirWay, out_dirHit, out_sset, out_tag, out_opcode, out_channel, out_mshrTask,
           out_stamp
  );
endinterface

// File: rtl/l2mp_trace_replayer.sv
// Buffers stamped L2 MainPipe trace records and re-emits each when the replay counter reaches its stamp.
// Optional build macro L2MP_REPLAY_ORDER_CHECK_EN adds sticky detection of decreasing push stamps.
module l2mp_trace_replayer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             eos,
  l2mp_trace_replayer_if.slave bus,
  output logic [63:0]      cycle,
  output logic [CNT_W-1:0] late_cnt,
  output logic             done,
  output logic             order_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 60;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [REC_W-1:0]  rec_mem_q   [DEPTH];
  logic [63:0]       stamp_mem_q [DEPTH];
  logic [63:0]       cycle_q, cycle_d;
  logic [CNT_W-1:0]  late_q, late_d;
  logic              done_q, done_d;
  logic              out_valid_q;
  logic [REC_W-1:0]  out_rec_q;
  logic [63:0]       out_stamp_q;

  logic              full, empty, push, emit, clr;
  logic [REC_W-1:0]  in_rec, head_rec;
  logic [63:0]       head_stamp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_rec = {bus.in_metaWway, bus.in_metaWvalid, bus.in_mshrId, bus.in_allocPtr,
                   bus.in_allocValid, bus.in_dirWay, bus.in_dirHit, bus.in_sset, bus.in_tag,
                   bus.in_opcode, bus.in_channel, bus.in_mshrTask};

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign bus.in_ready = (state_q != DONE) && !full;
  assign push       = bus.in_valid && bus.in_ready;
  assign head_rec   = rec_mem_q[rd_ptr_q[AW-1:0]];
  assign head_stamp = stamp_mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    late_d  = late_q;
    done_d  = done_q;
    emit    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        cycle_d = '0;
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          cycle_d = '0;
          clr     = 1'b1;
        end else begin
          cycle_d = cycle_q + 64'd1;
          emit    = !empty && (head_stamp <= cycle_q);
          if (emit && (head_stamp < cycle_q)) late_d = sat_inc(late_q);
          // An emit implies non-empty, so reaching here empty means nothing is left to pop.
          if (eos && empty && !push) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          cycle_d = '0;
          done_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) late_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cycle_q     <= '0;
      late_q      <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_rec_q   <= '0;
      out_stamp_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      late_q      <= late_d;
      done_q      <= done_d;
      out_valid_q <= emit;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (emit) begin
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        out_rec_q   <= head_rec;
        out_stamp_q <= head_stamp;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      rec_mem_q[wr_ptr_q[AW-1:0]]   <= in_rec;
      stamp_mem_q[wr_ptr_q[AW-1:0]] <= bus.in_stamp;
    end
  end

`ifdef L2MP_REPLAY_ORDER_CHECK_EN
  logic [63:0] last_stamp_q;
  logic        order_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_stamp_q <= '0;
      order_err_q  <= 1'b0;
    end else begin
      if (push) last_stamp_q <= bus.in_stamp;
      if (clr) order_err_q <= 1'b0;
      else if (push && (bus.in_stamp < last_stamp_q)) order_err_q <= 1'b1;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign {bus.out_metaWway, bus.out_metaWvalid, bus.out_mshrId, bus.out_allocPtr,
          bus.out_allocValid, bus.out_dirWay, bus.out_dirHit, bus.out_sset, bus.out_tag,
          bus.out_opcode, bus.out_channel, bus.out_mshrTask} = out_rec_q;
  assign bus.out_stamp = out_stamp_q;
  assign cycle         = cycle_q;
  assign late_cnt      = late_q;
  assign done          = done_q;

endmodule

// File: tb/tb_l2mp_trace_replayer.sv
// Scoreboard bench for l2mp_trace_replayer: directed pushes queue expected emits,
// a negedge monitor pops and compares fields, stamp and emit cycle.
module tb_l2mp_trace_replayer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef L2MP_REPLAY_ORDER_CHECK_EN
  localparam logic EXP_ORD = 1'b1;
`else
  localparam logic EXP_ORD = 1'b0;
`endif

  typedef struct {
    logic [59:0] rec;
    logic [63:0] stamp;
    logic [63:0] cyc;
  } exp_t;

  logic             clock;
  logic             reset;
  logic             start;
  logic             eos;
  logic [63:0]      cycle;
  logic [CNT_W-1:0] late_cnt;
  logic             done;
  logic             order_err;
  logic [59:0]      out_rec;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t e;

  l2mp_trace_replayer_if bus ();

  l2mp_trace_replayer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .eos      (eos),
    .bus      (bus),
    .cycle    (cycle),
    .late_cnt (late_cnt),
    .done     (done),
    .order_err(order_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign out_rec = {bus.out_metaWway, bus.out_metaWvalid, bus.out_mshrId, bus.out_allocPtr,
                    bus.out_allocValid, bus.out_dirWay, bus.out_dirHit, bus.out_sset, bus.out_tag,
                    bus.out_opcode, bus.out_channel, bus.out_mshrTask};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [59:0] mkrec(input int k);
    logic [63:0] t;
    t = 64'h0F1E_2D3C_4B5A_6978 ^ (64'(k) * 64'h1111_1111_1111_1111);
    return t[59:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic [59:0] rec, input logic [63:0] stamp);
    {bus.in_metaWway, bus.in_metaWvalid, bus.in_mshrId, bus.in_allocPtr, bus.in_allocValid,
     bus.in_dirWay, bus.in_dirHit, bus.in_sset, bus.in_tag, bus.in_opcode, bus.in_channel,
     bus.in_mshrTask} = rec;
    bus.in_stamp = stamp;
  endtask

  task automatic push(input logic [59:0] rec, input logic [63:0] stamp,
                      input logic [63:0] exp_cyc, input bit track);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    drive(rec, stamp);
    bus.in_valid = 1'b1;
    if (track) sbq.push_back(exp_t'{rec, stamp, exp_cyc});
    while (!acc && n < 100) begin
      acc = bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout stamp=%0d actual=not_accepted required=accepted", stamp);
    end
  endtask

  task automatic wait_cycle(input logic [63:0] c);
    int n;
    n = 0;
    while (cycle != c && n < 200) begin
      tick();
      n++;
    end
    check("wait_cycle", cycle, c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: every emit must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_emit actual=stamp %0d at cycle %0d required=no emit",
                 bus.out_stamp, cycle);
      end else begin
        e = sbq.pop_front();
        check("emit_fields", {4'h0, out_rec}, {4'h0, e.rec});
        check("emit_stamp", bus.out_stamp, e.stamp);
        check("emit_cycle", cycle, e.cyc);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    eos   = 1'b0;
    bus.in_valid = 1'b0;
    drive('0, '0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_cycle", cycle, 64'd0);
    check("rst_late", {48'd0, late_cnt}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_order_err", {63'd0, order_err}, 64'd0);

    // Stamps 5,7,7 loaded in IDLE; the second 7 goes out one cycle late.
    push(mkrec(1), 64'd5, 64'd6, 1'b1);
    push(mkrec(2), 64'd7, 64'd8, 1'b1);
    push(mkrec(3), 64'd7, 64'd9, 1'b1);
    check("idle_cycle_hold", cycle, 64'd0);
    pulse_start();
    check("start_cycle_zero", cycle, 64'd0);
    wait_cycle(64'd10);
    check("late_after_sevens", {48'd0, late_cnt}, 64'd1);

    // Stale stamp 0 pushed at cycle 10 pops immediately.
    push(mkrec(4), 64'd0, 64'd12, 1'b1);
    tick();
    check("late_after_stale", {48'd0, late_cnt}, 64'd2);

    // Fill with far-future stamps, then hold a fifth record off until the first pop.
    push(mkrec(5), 64'd40, 64'd41, 1'b1);
    push(mkrec(6), 64'd41, 64'd42, 1'b1);
    push(mkrec(7), 64'd42, 64'd43, 1'b1);
    push(mkrec(8), 64'd43, 64'd44, 1'b1);
    check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    drive(mkrec(9), 64'd44);
    bus.in_valid = 1'b1;
    sbq.push_back(exp_t'{mkrec(9), 64'd44, 64'd45});
    wait_cycle(64'd40);
    check("held_in_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    check("pop_restores_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;

    // End of stream with two records pending.
    push(mkrec(10), 64'd50, 64'd51, 1'b1);
    push(mkrec(11), 64'd51, 64'd52, 1'b1);
    eos = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      check("done_before_drain", {63'd0, done}, 64'd0);
      tick();
      n++;
    end
    check("done_rise", {63'd0, done}, 64'd1);
    check("done_cycle", cycle, 64'd53);
    check("done_drained", 64'(sbq.size()), 64'd0);
    check("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("done_late", {48'd0, late_cnt}, 64'd2);
    drive(mkrec(12), 64'd0);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check("done_cycle_stops", cycle, 64'd53);
    eos = 1'b0;
    pulse_start();
    check("restart_done_clr", {63'd0, done}, 64'd0);
    check("restart_late_clr", {48'd0, late_cnt}, 64'd0);
    check("restart_cycle", cycle, 64'd0);

    // Reset with three queued records flushes them.
    push(mkrec(13), 64'd30, 64'd0, 1'b0);
    push(mkrec(14), 64'd31, 64'd0, 1'b0);
    push(mkrec(15), 64'd32, 64'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("midrst_cycle", cycle, 64'd0);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    repeat (5) tick();
    check("midrst_idle_hold", cycle, 64'd0);
    pulse_start();
    repeat (40) tick();
    check("midrst_run_cycle", cycle, 64'd40);

    // Decreasing stamps: both emitted, order_err per build.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(mkrec(16), 64'd10, 64'd11, 1'b1);
    push(mkrec(17), 64'd4, 64'd12, 1'b1);
    check("order_err_set", {63'd0, order_err}, {63'd0, EXP_ORD});
    pulse_start();
    check("order_err_start_clr", {63'd0, order_err}, 64'd0);
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("order_drained", 64'(sbq.size()), 64'd0);
    check("order_late", {48'd0, late_cnt}, 64'd1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
